fifo_rd_ctrl: RTL and testbench
===============================

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the FIFO/stream data width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the delivered-word counter width.
REQ-003 The block SHALL have port rd_clk, input, 1 bit: the single clock, the FIFO read-side clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port enable_i, input, 1 bit: run request.
REQ-006 The block SHALL have port fifo_empty_i, input, 1 bit: FIFO empty flag.
REQ-007 The block SHALL have port fifo_rdata_i, input, DATA_W bits: FIFO read data.
REQ-008 The block SHALL have port fifo_underflw_i, input, 1 bit: FIFO underflow flag.
REQ-009 The block SHALL have port fifo_rden_o, output, 1 bit: FIFO read enable.
REQ-010 The block SHALL have port m_data_o, output, DATA_W bits: stream data.
REQ-011 The block SHALL have port m_valid_o, output, 1 bit: stream valid.
REQ-012 The block SHALL have port m_ready_i, input, 1 bit: stream ready.
REQ-013 The block SHALL have port rd_count_o, output, CNT_W bits: delivered-word count.
REQ-014 The block SHALL have port underflw_err_o, output, 1 bit: sticky underflow error.
REQ-015 The block SHALL have port busy_o, output, 1 bit: activity indicator.

Function
REQ-016 FIFO read latency SHALL be one cycle: the word for a rden asserted at edge N is captured from fifo_rdata_i at edge N+1.
REQ-017 The block SHALL hold a 3-entry in-order output buffer; occ = buffered words, infl = reads issued but not yet captured (0 or 1).
REQ-018 fifo_rden_o SHALL equal (state==RUN) && !fifo_empty_i && (occ+infl < 3), computed from registered occ/infl only, never from m_ready_i.
REQ-019 Given REQ-018, sustained m_ready_i=1 with a non-empty FIFO SHALL yield one word per cycle after a 2-cycle startup.
REQ-020 m_valid_o SHALL equal (occ != 0); m_data_o SHALL be the oldest buffered word.
REQ-021 A handshake SHALL occur on m_valid_o && m_ready_i; m_data_o and m_valid_o SHALL stay stable while m_valid_o && !m_ready_i.
REQ-022 Capture and handshake in the same cycle SHALL leave occ unchanged with order preserved; the buffer SHALL never overflow or drop or duplicate a word.
REQ-023 FSM states: IDLE, RUN, DRAIN.
REQ-024 FSM transition: IDLE -> RUN when enable_i=1.
REQ-025 FSM transition: RUN -> DRAIN when enable_i=0.
REQ-026 FSM transition: DRAIN -> IDLE when occ==0 && infl==0.
REQ-027 FSM transition: DRAIN -> RUN when enable_i=1.
REQ-028 In DRAIN, no new reads SHALL be issued; the in-flight read SHALL still be captured and buffered words delivered.
REQ-029 busy_o SHALL equal (state != IDLE) || occ != 0 || infl != 0.
REQ-030 rd_count_o SHALL increment by 1 per handshake and wrap from 2^CNT_W-1 to 0.
REQ-031 underflw_err_o SHALL set on any cycle where fifo_underflw_i=1 and SHALL hold until reset.
REQ-032 A fifo_empty_i that rises in the same cycle as a rden-qualifying check SHALL suppress that rden (rden is combinational on fifo_empty_i).

Reset
REQ-033 While rst_n=0, all outputs SHALL be 0 regardless of rd_clk: fifo_rden_o, m_valid_o, m_data_o, rd_count_o, underflw_err_o, busy_o.
REQ-034 Reset SHALL force state=IDLE, occ=0, infl=0; buffered and in-flight words SHALL be discarded, including on reset mid-operation.
REQ-035 Operation SHALL resume at the first rd_clk edge after rst_n deasserts, if enable_i=1.

Verification
REQ-036 Streaming: FIFO preloaded with 0x01..0x10, enable_i=1, m_ready_i=1 -> words 0x01..0x10 delivered in order, one per cycle from the third edge; rd_count_o=16; then fifo_rden_o=0.
REQ-037 Backpressure: m_ready_i=0 for 10 cycles with a non-empty FIFO -> exactly 3 rden pulses, occ=3, m_data_o held at the first word; on release all words delivered in order without loss.
REQ-038 Drain: enable_i dropped one cycle after a rden -> no further rden, in-flight word delivered, busy_o falls once the buffer is empty, state=IDLE.
REQ-039 Underflow: pulse fifo_underflw_i for 1 cycle -> underflw_err_o=1 and stays 1 until rst_n=0.
REQ-040 Reset mid-run: assert rst_n=0 with occ=2, infl=1 -> outputs immediately 0; after release with 0x20 next in the FIFO, the first delivered word is 0x20.
REQ-041 Wrap: CNT_W=4, 17 handshakes -> rd_count_o=1.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_ctrl
// Description : Read-side controller that pulls words out of a synchronous
//               FIFO (one-cycle read latency) and presents them on a
//               valid/ready stream through a 3-entry in-order buffer.
//               Provides a delivered-word counter, a sticky underflow error
//               flag and a busy indicator.
//
// Ports
//   rd_clk          in   1       FIFO read-side clock, rising edge
//   rst_n           in   1       asynchronous active-low reset
//   enable_i        in   1       run request
//   fifo_empty_i    in   1       FIFO empty flag
//   fifo_rdata_i    in   DATA_W  FIFO read data (valid one cycle after rden)
//   fifo_underflw_i in   1       FIFO underflow flag
//   fifo_rden_o     out  1       FIFO read enable
//   m_data_o        out  DATA_W  stream data (oldest buffered word)
//   m_valid_o       out  1       stream valid
//   m_ready_i       in   1       stream ready
//   rd_count_o      out  CNT_W   delivered-word count (wraps)
//   underflw_err_o  out  1       sticky underflow error
//   busy_o          out  1       activity indicator
//
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              rd_clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_rdata_i,
  input  logic              fifo_underflw_i,
  output logic              fifo_rden_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [CNT_W-1:0]  rd_count_o,
  output logic              underflw_err_o,
  output logic              busy_o
);

  localparam int          DEPTH     = 3;
  localparam logic [2:0]  SLOTS_MAX = 3'd3;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [1:0]        occ;         // words held in the buffer (0..3)
  logic              infl;        // a read was issued last cycle, data arrives now
  logic [1:0]        rd_ptr;      // oldest buffered entry
  logic [1:0]        wr_ptr;      // next free entry
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  count;
  logic              uerr;

  logic [2:0]        slots_used;
  logic              rden;
  logic              handshake;

  // Circular pointer step over the three buffer entries.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A slot is reserved as soon as a read is issued, so the buffer can never
  // be asked to accept a word it has no room for. Ready is deliberately not
  // part of this decision to keep the stream ready path off the FIFO side.
  assign slots_used = {1'b0, occ} + {2'b00, infl};
  assign rden       = (state == ST_RUN) && !fifo_empty_i && (slots_used < SLOTS_MAX);
  assign handshake  = (occ != 2'd0) && m_ready_i;

  // --------------------------------------------------------------------------
  // Control state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable_i) state <= ST_RUN;
        end
        ST_RUN: begin
          if (!enable_i) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Re-enable takes priority over finishing the drain.
          if (enable_i) begin
            state <= ST_RUN;
          end else if ((occ == 2'd0) && !infl) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read tracking and output buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      infl   <= 1'b0;
      occ    <= 2'd0;
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      infl <= rden;

      // The word requested last cycle is on fifo_rdata_i now.
      if (infl) begin
        mem[wr_ptr] <= fifo_rdata_i;
        wr_ptr      <= ptr_inc(wr_ptr);
      end

      if (handshake) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end

      // Simultaneous capture and handshake leave the occupancy unchanged.
      case ({infl, handshake})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Delivered-word counter and sticky underflow flag
  // --------------------------------------------------------------------------
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      uerr  <= 1'b0;
    end else begin
      if (handshake) begin
        count <= count + CNT_ONE;
      end
      if (fifo_underflw_i) begin
        uerr <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign fifo_rden_o    = rden;
  assign m_valid_o      = (occ != 2'd0);
  // Data is forced to zero while nothing is buffered so stale entries never
  // appear on the stream.
  assign m_data_o       = m_valid_o ? mem[rd_ptr] : '0;
  assign rd_count_o     = count;
  assign underflw_err_o = uerr;
  assign busy_o         = (state != ST_IDLE) || (occ != 2'd0) || infl;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_ctrl
// Description : Self-checking bench for fifo_rd_ctrl. A behavioural FIFO
//               feeds the design; a queue-based reference tracks every word
//               popped from the FIFO and the order it must be delivered in.
//               A second instance with a 4-bit counter shares all stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_ctrl;

  logic        rd_clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic        fifo_empty_i;
  logic [7:0]  fifo_rdata_i;
  logic        fifo_underflw_i;
  logic        m_ready_i;

  logic        fifo_rden_o,    rden4;
  logic [7:0]  m_data_o,       data4;
  logic        m_valid_o,      valid4;
  logic [15:0] rd_count_o;
  logic [3:0]  count4;
  logic        underflw_err_o, uerr4;
  logic        busy_o,         busy4;

  fifo_rd_ctrl #(.DATA_W(8), .CNT_W(16)) dut (
    .rd_clk(rd_clk), .rst_n(rst_n), .enable_i(enable_i),
    .fifo_empty_i(fifo_empty_i), .fifo_rdata_i(fifo_rdata_i),
    .fifo_underflw_i(fifo_underflw_i), .fifo_rden_o(fifo_rden_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .rd_count_o(rd_count_o), .underflw_err_o(underflw_err_o), .busy_o(busy_o)
  );

  fifo_rd_ctrl #(.DATA_W(8), .CNT_W(4)) dut4 (
    .rd_clk(rd_clk), .rst_n(rst_n), .enable_i(enable_i),
    .fifo_empty_i(fifo_empty_i), .fifo_rdata_i(fifo_rdata_i),
    .fifo_underflw_i(fifo_underflw_i), .fifo_rden_o(rden4),
    .m_data_o(data4), .m_valid_o(valid4), .m_ready_i(m_ready_i),
    .rd_count_o(count4), .underflw_err_o(uerr4), .busy_o(busy4)
  );

  always #5 rd_clk = ~rd_clk;

  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] fifo_q[$];   // FIFO contents not yet read
  logic [7:0] exp_q[$];    // words read from the FIFO, not yet delivered
  logic [7:0] got_q[$];    // words actually delivered by the DUT
  int         mode;
  bit         infl;        // a read was issued at the last edge
  int         cnt;
  bit         uerr_m;
  int         rden_pulses;
  bit         last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    got_q.delete();
    mode   = M_IDLE;
    infl   = 1'b0;
    cnt    = 0;
    uerr_m = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rden"},  fifo_rden_o,    0);
    chk({tag, "_valid"}, m_valid_o,      0);
    chk({tag, "_data"},  m_data_o,       0);
    chk({tag, "_count"}, rd_count_o,     0);
    chk({tag, "_uerr"},  underflw_err_o, 0);
    chk({tag, "_busy"},  busy_o,         0);
    chk({tag, "_cnt4"},  count4,         0);
    chk({tag, "_busy4"}, busy4,          0);
  endtask

  // One clock cycle. Entered at a falling edge with inputs already set.
  task automatic step();
    int         captured;
    bit         exp_rden, exp_valid, hs, rd;
    logic [7:0] w;
    fifo_empty_i = (fifo_q.size() == 0);
    #1;
    captured  = exp_q.size() - int'(infl);
    exp_rden  = (mode == M_RUN) && !fifo_empty_i && (exp_q.size() < 3);
    exp_valid = (captured > 0);
    chk("rden",   fifo_rden_o, exp_rden);
    chk("rden4",  rden4,       exp_rden);
    chk("valid",  m_valid_o,   exp_valid);
    chk("valid4", valid4,      exp_valid);
    if (exp_valid) begin
      chk("data",  m_data_o, exp_q[0]);
      chk("data4", data4,    exp_q[0]);
    end
    chk("busy",  busy_o,         (mode != M_IDLE) || (exp_q.size() != 0));
    chk("count", rd_count_o,     cnt & 32'hFFFF);
    chk("cnt4",  count4,         cnt & 32'hF);
    chk("uerr",  underflw_err_o, uerr_m);
    hs = exp_valid && m_ready_i;
    rd = fifo_rden_o;
    if (hs) got_q.push_back(m_data_o);
    @(posedge rd_clk);
    if (fifo_underflw_i) uerr_m = 1'b1;
    case (mode)
      M_IDLE:  if (enable_i) mode = M_RUN;
      M_RUN:   if (!enable_i) mode = M_DRAIN;
      default: if (enable_i) mode = M_RUN;
               else if (exp_q.size() == 0) mode = M_IDLE;
    endcase
    if (hs) begin
      void'(exp_q.pop_front());
      cnt++;
    end
    w = 8'($urandom);
    if (rd) begin
      rden_pulses++;
      if (fifo_q.size() > 0) w = fifo_q.pop_front();
      exp_q.push_back(w);
    end
    infl    = rd;
    last_rd = rd;
    @(negedge rd_clk);
    // Read data appears one cycle after the request; otherwise bus noise.
    fifo_rdata_i = rd ? w : 8'($urandom);
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0; enable_i = 1'b0; m_ready_i = 1'b0;
    fifo_empty_i = 1'b1; fifo_underflw_i = 1'b0; fifo_rdata_i = 8'h00;
    rden_pulses = 0; last_rd = 1'b0;
    model_reset();
    repeat (2) @(negedge rd_clk);
    #1 check_zero("reset");
    @(negedge rd_clk);

    // Streaming: 0x01..0x10 delivered in order.
    for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
    enable_i = 1'b1; m_ready_i = 1'b1; rst_n = 1'b1;
    repeat (22) step();
    chk("stream_count", rd_count_o, 16);
    chk("stream_n", got_q.size(), 16);
    for (int i = 0; i < 16 && i < got_q.size(); i++) chk("stream_word", got_q[i], i + 1);
    chk("stream_rden_off", fifo_rden_o, 0);

    // Backpressure: exactly three reads, head held.
    m_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'h41 + 8'(i));
    rden_pulses = 0;
    repeat (10) step();
    chk("bp_pulses", rden_pulses, 3);
    chk("bp_head", m_data_o, 8'h41);
    chk("bp_valid", m_valid_o, 1);
    m_ready_i = 1'b1;
    repeat (14) step();
    chk("bp_count", rd_count_o, 24);

    // Drain: drop enable right after a read.
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'h51 + 8'(i));
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      step();
      ok = last_rd;
    end
    chk("drain_saw_rden", ok, 1);
    enable_i = 1'b0;
    repeat (10) step();
    chk("drain_busy", busy_o, 0);
    chk("drain_rden", fifo_rden_o, 0);

    // Underflow is sticky.
    fifo_underflw_i = 1'b1;
    step();
    fifo_underflw_i = 1'b0;
    repeat (4) step();
    chk("uerr_sticky", underflw_err_o, 1);
    chk("uerr_sticky4", uerr4, 1);

    // Randomised traffic with enable toggling and bursty ready.
    enable_i = 1'b1;
    repeat (400) begin
      m_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) enable_i = ~enable_i;
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 20) fifo_q.push_back(8'($urandom));
      step();
    end

    // Reset mid-run with two words buffered and one in flight.
    enable_i = 1'b0; m_ready_i = 1'b1;
    repeat (15) step();
    fifo_q.delete();
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'h61 + 8'(i));
    enable_i = 1'b1; m_ready_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      ok = (exp_q.size() == 3) && infl;
    end
    chk("midrun_reached", ok, 1);
    chk("midrun_busy", busy_o, 1);
    rst_n = 1'b0;
    #1 check_zero("midrst");
    model_reset();
    fifo_q.delete();
    for (int i = 0; i < 17; i++) fifo_q.push_back(8'h20 + 8'(i));
    @(posedge rd_clk);
    @(negedge rd_clk);
    m_ready_i = 1'b1;
    rst_n = 1'b1;
    repeat (24) step();
    chk("post_rst_n", got_q.size(), 17);
    if (got_q.size() > 0) chk("post_rst_first", got_q[0], 8'h20);
    chk("post_rst_count", rd_count_o, 17);
    chk("wrap4", count4, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
